cnu_sched: RTL and testbench

- Sequences one check-node compare tree (min/min2/min_idx, 1-cycle registered latency, gated by `en`) across all check rows of the LDPC min-sum decoder.
- Per iteration it reads each row's packed V2C word from message memory, splits sign from magnitude, and drives magnitudes into the tree.
- It writes a compressed C2V record per row, with backpressure from the write side.
- It repeats for a programmed iteration count, with early termination on syndrome pass.

---
 rtl/cnu_sched.sv | 164 ++++++++++++++++
 tb/tb_cnu_sched.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnu_sched.sv
// Check-node scheduler: streams every row's V2C word through one shared min/min2 compare
// tree and emits one compressed C2V record per row, iterating until done or syndrome pass.
module cnu_sched #(
  parameter int unsigned D      = 5,
  parameter int unsigned MSG_W  = 6,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ITER_W = 6,
  localparam int unsigned MAG_W = MSG_W - 1,
  localparam int unsigned WR_W  = D + 1 + IDX_W + 2 * MAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ITER_W-1:0]     n_iter,
  input  logic                  syndrome_ok,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [D*MSG_W-1:0]    rd_data,
  output logic                  tree_en,
  output logic [D*MAG_W-1:0]    tree_in,
  input  logic [MAG_W-1:0]      tree_min,
  input  logic [MAG_W-1:0]      tree_min2,
  input  logic [IDX_W-1:0]      tree_min_idx,
  output logic                  wr_en,
  input  logic                  wr_ready,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [WR_W-1:0]       wr_data,
  output logic                  busy,
  output logic                  done,
  output logic [ITER_W-1:0]     iters_done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   row_cnt;
  logic [ITER_W-1:0]   n_iter_q;
  logic [ITER_W-1:0]   iters_inc;

  logic                rd_vld_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                skid_vld;
  logic [D*MSG_W-1:0]  skid_data;
  logic [ADDR_W-1:0]   skid_addr;
  logic                b_vld;
  logic [D-1:0]        b_signs;
  logic                b_sgn;
  logic [ADDR_W-1:0]   b_addr;

  logic                adv;
  logic                issue;
  logic                last_row;
  logic                drain_empty;
  logic                a_vld;
  logic [D*MSG_W-1:0]  a_data;
  logic [ADDR_W-1:0]   a_addr;
  logic [D-1:0]        a_signs;
  logic [D*MAG_W-1:0]  a_mags;

  // The whole pipe advances unless a pending record is being refused.
  assign adv         = !(b_vld && !wr_ready);
  assign issue       = (state == RUN) && adv && !skid_vld;
  assign last_row    = (row_cnt == ADDR_W'(ROWS - 1));
  assign drain_empty = !rd_vld_q && !skid_vld && !b_vld;
  assign iters_inc   = iters_done + ITER_W'(1);

  // Stage A source: a held skid entry always wins over the live read return.
  assign a_vld  = rd_vld_q || skid_vld;
  assign a_data = skid_vld ? skid_data : rd_data;
  assign a_addr = skid_vld ? skid_addr : rd_addr_q;

  always_comb begin
    a_signs = '0;
    a_mags  = '0;
    for (int unsigned k = 0; k < D; k++) begin
      a_signs[k]                 = a_data[k*MSG_W + MSG_W - 1];
      a_mags[k*MAG_W +: MAG_W]   = a_data[k*MSG_W +: MAG_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_iter == '0) ? FIN : RUN;
      RUN:     if (issue && last_row) state_nxt = DRAIN;
      DRAIN:   if (drain_empty) state_nxt = (syndrome_ok || iters_inc == n_iter_q) ? FIN : RUN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_en   = issue;
    rd_addr = row_cnt;
    busy    = (state == RUN) || (state == DRAIN);
    done    = (state == FIN);
    tree_en = a_vld && adv;
    tree_in = tree_en ? a_mags : '0;
    wr_en   = b_vld;
    wr_addr = b_addr;
    wr_data = b_vld ? {b_signs, b_sgn, tree_min_idx, tree_min2, tree_min} : '0;
  end

  // Row / iteration bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt    <= '0;
      n_iter_q   <= '0;
      iters_done <= '0;
    end else begin
      if (state == IDLE && start) begin
        n_iter_q   <= n_iter;
        row_cnt    <= '0;
        iters_done <= '0;
      end
      if (issue) row_cnt <= row_cnt + ADDR_W'(1);
      if (state == DRAIN && drain_empty) begin
        iters_done <= iters_inc;
        row_cnt    <= '0;
      end
    end
  end

  // Read return tracking, skid capture and stage-B sign/address register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= 1'b0;
      rd_addr_q <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      skid_addr <= '0;
      b_vld     <= 1'b0;
      b_signs   <= '0;
      b_sgn     <= 1'b0;
      b_addr    <= '0;
    end else begin
      rd_vld_q <= issue;
      if (issue) rd_addr_q <= row_cnt;
      if (adv) begin
        skid_vld <= 1'b0;
      end else if (rd_vld_q && !skid_vld) begin
        skid_vld  <= 1'b1;
        skid_data <= rd_data;
        skid_addr <= rd_addr_q;
      end
      if (adv) begin
        b_vld <= tree_en;
        if (tree_en) begin
          b_signs <= a_signs;
          b_sgn   <= ^a_signs;
          b_addr  <= a_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_cnu_sched.sv
// Bench for cnu_sched: memory and compare-tree models, random backpressure, and a
// scoreboard of expected C2V records derived from the row contents.
module tb_cnu_sched;

  localparam int unsigned D      = 5;
  localparam int unsigned MSG_W  = 6;
  localparam int unsigned MAG_W  = MSG_W - 1;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned ROWS   = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned ITER_W = 6;
  localparam int unsigned RW     = D * MSG_W;
  localparam int unsigned WW     = D + 1 + IDX_W + 2 * MAG_W;

  logic              clk, rst, start, syndrome_ok;
  logic [ITER_W-1:0] n_iter;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [RW-1:0]     rd_data;
  logic              tree_en;
  logic [D*MAG_W-1:0] tree_in;
  logic [MAG_W-1:0]  tree_min, tree_min2;
  logic [IDX_W-1:0]  tree_min_idx;
  logic              wr_en, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [WW-1:0]     wr_data;
  logic              busy, done;
  logic [ITER_W-1:0] iters_done;

  cnu_sched #(.D(D), .MSG_W(MSG_W), .IDX_W(IDX_W), .ROWS(ROWS), .ADDR_W(ADDR_W), .ITER_W(ITER_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_iter(n_iter), .syndrome_ok(syndrome_ok),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .tree_en(tree_en), .tree_in(tree_in), .tree_min(tree_min), .tree_min2(tree_min2),
    .tree_min_idx(tree_min_idx), .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .iters_done(iters_done)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WW-1:0]     data;
  } rec_t;

  rec_t          sb[$];
  logic [RW-1:0] mem [ROWS];
  int            errors = 0;
  int            checks = 0;
  int            rec_cnt, rd_cnt, stall_cnt, first_t, last_t, cyc;
  int            rdy_mode, rdy_pct, stop_after, phase;
  logic [WW-1:0] first_rec;
  logic [5:0]    pat;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected record: smallest magnitude, its first position, smallest of the rest.
  function automatic logic [WW-1:0] ref_rec(input logic [RW-1:0] w);
    int m[D];
    logic [D-1:0] s;
    int mn, mn2, idx;
    for (int k = 0; k < int'(D); k++) begin
      s[k] = w[k*MSG_W + MSG_W - 1];
      m[k] = int'(w[k*MSG_W +: MAG_W]);
    end
    mn = 1 << MAG_W;
    foreach (m[k]) if (m[k] < mn) mn = m[k];
    idx = -1;
    foreach (m[k]) if (idx < 0 && m[k] == mn) idx = k;
    mn2 = 1 << MAG_W;
    foreach (m[k]) if (k != idx && m[k] < mn2) mn2 = m[k];
    return {s, ^s, IDX_W'(idx), MAG_W'(mn2), MAG_W'(mn)};
  endfunction

  // Compare-tree model: running min/min2 scan, registered on tree_en.
  function automatic logic [IDX_W+2*MAG_W-1:0] tree_eval(input logic [D*MAG_W-1:0] v);
    logic [MAG_W-1:0] a, b, x;
    int ix;
    a = v[0 +: MAG_W];
    b = '1;
    ix = 0;
    for (int k = 1; k < int'(D); k++) begin
      x = v[k*MAG_W +: MAG_W];
      if (x < a) begin b = a; a = x; ix = k; end
      else if (x < b) b = x;
    end
    return {IDX_W'(ix), b, a};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) {tree_min_idx, tree_min2, tree_min} <= '0;
    else if (tree_en) {tree_min_idx, tree_min2, tree_min} <= tree_eval(tree_in);
  end

  // Message memory: data valid exactly one cycle after rd_en, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? mem[int'(rd_addr) % ROWS] : RW'($urandom);

  // wr_ready and syndrome driver.
  initial begin
    wr_ready = 1'b1;
    syndrome_ok = 1'b0;
    phase = 0;
    pat = 6'b101001;
    forever begin
      @(posedge clk);
      #1;
      phase++;
      case (rdy_mode)
        1:       wr_ready = pat[phase % 6];
        2:       wr_ready = ($urandom_range(99) < rdy_pct);
        default: wr_ready = 1'b1;
      endcase
      syndrome_ok = (stop_after != 0) && (rec_cnt >= stop_after * int'(ROWS));
    end
  end

  // Monitor: stall stability and in-order record scoreboard.
  initial begin
    rec_t e;
    logic              stalled;
    logic [WW-1:0]     held_data;
    logic [ADDR_W-1:0] held_addr;
    stalled = 1'b0;
    held_data = '0;
    held_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_hold_en", wr_en, 1);
          chk("stall_hold_data", wr_data, held_data);
          chk("stall_hold_addr", wr_addr, held_addr);
        end
        if (wr_en && wr_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_record", wr_addr, '1);
          end else begin
            e = sb.pop_front();
            chk("rec_addr", wr_addr, e.addr);
            chk("rec_data", wr_data, e.data);
          end
          if (rec_cnt == 0) begin first_rec = wr_data; first_t = cyc; end
          last_t = cyc;
          rec_cnt++;
        end
        if (wr_en && !wr_ready) stall_cnt++;
        stalled   = wr_en && !wr_ready;
        held_data = wr_data;
        held_addr = wr_addr;
        if (rd_en) rd_cnt++;
      end
    end
  end

  task automatic fill_mem();
    for (int r = 0; r < int'(ROWS); r++) mem[r] = RW'($urandom);
  endtask

  task automatic push_exp(input int iters);
    for (int it = 0; it < iters; it++)
      for (int r = 0; r < int'(ROWS); r++) sb.push_back('{ADDR_W'(r), ref_rec(mem[r])});
  endtask

  task automatic run(input int n, input int stop_k, input int mode, input bit poke);
    int exp_it, w;
    exp_it = (n == 0) ? 0 : ((stop_k == 0 || stop_k > n) ? n : stop_k);
    rdy_mode = mode;
    rdy_pct = $urandom_range(90, 30);
    stop_after = stop_k;
    rec_cnt = 0;
    rd_cnt = 0;
    stall_cnt = 0;
    push_exp(exp_it);
    start = 1'b1;
    n_iter = ITER_W'(n);
    @(negedge clk);
    start = 1'b0;
    if (n != 0) chk("busy_after_start", busy, 1);
    if (poke) begin
      repeat (2) @(negedge clk);
      start = 1'b1;
      n_iter = ITER_W'(n + 5);
      @(negedge clk);
      start = 1'b0;
      n_iter = ITER_W'(n);
    end
    w = 0;
    while (!done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("done_seen", done, 1);
    if (n == 0) chk("zero_iter_done_fast", w <= 1, 1);
    chk("busy_at_done", busy, 0);
    chk("iters_done", iters_done, exp_it);
    chk("record_count", rec_cnt, exp_it * int'(ROWS));
    chk("read_count", rd_cnt, exp_it * int'(ROWS));
    chk("scoreboard_empty", sb.size(), 0);
    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("iters_hold", iters_done, exp_it);
    stop_after = 0;
    @(negedge clk);
  endtask

  initial begin
    int w;
    logic [MAG_W-1:0] m0 [D];
    logic [D-1:0] s0;
    rst = 1'b1;
    start = 1'b0;
    n_iter = '0;
    rdy_mode = 0;
    stop_after = 0;
    rec_cnt = 0;
    rd_cnt = 0;
    stall_cnt = 0;
    fill_mem();
    m0 = '{5'd7, 5'd3, 5'd9, 5'd4, 5'd12};
    s0 = 5'b11001;
    for (int k = 0; k < int'(D); k++) mem[0][k*MSG_W +: MSG_W] = {s0[k], m0[k]};
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_tree_en", tree_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_iters", iters_done, 0);
    chk("rst_wr_data", wr_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic single iteration, no backpressure.
    run(1, 0, 0, 1'b0);
    chk("basic_row0_record", first_rec, {5'b11001, 1'b1, 8'd1, 5'd4, 5'd3});
    chk("basic_back_to_back", last_t - first_t, ROWS - 1);

    // Fixed 1,0,0,1,0,1 backpressure.
    run(1, 0, 1, 1'b0);
    chk("bp_stalls_seen", stall_cnt > 0, 1);

    run(3, 0, 0, 1'b0);
    run(3, 1, 0, 1'b0);
    run(0, 0, 0, 1'b0);
    run(2, 0, 2, 1'b1);

    // Reset while row 2 of the second iteration sits in stage B.
    rdy_mode = 0;
    rec_cnt = 0;
    push_exp(2);
    start = 1'b1;
    n_iter = ITER_W'(2);
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(wr_en && wr_addr == ADDR_W'(2) && rec_cnt >= int'(ROWS)) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("midrun_reached", wr_en && wr_addr == ADDR_W'(2), 1);
    chk("midrun_iters", iters_done, 1);
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_wr_en", wr_en, 0);
    chk("midrst_wr_data", wr_data, 0);
    chk("midrst_tree_en", tree_en, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_iters", iters_done, 0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    run(1, 0, 0, 1'b0);
    chk("restart_row0_first", first_rec, ref_rec(mem[0]));

    // Randomized contents, iteration counts, early stop and backpressure.
    for (int i = 0; i < 10; i++) begin
      fill_mem();
      run($urandom_range(4, 1), $urandom_range(3, 0), 2, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
